// File: rtl/knight_cmd_sequencer.sv
// knight_cmd_sequencer
// Buffers 16-bit Knight commands in a FIFO and issues them one at a time to
// RemoteComm. It waits for cmd_snt and then for the response byte before it
// issues the next command. A response other than ACK, or no response within
// TMO_CLKS clocks of cmd_snt, aborts the run and flushes the buffer.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | accepting writes; waiting for go with a non-empty buffer
// S_LOAD      | copy head-of-buffer command onto cmd
// S_SEND      | snd_cmd pulse for one clock
// S_WAIT_SNT  | waiting for RemoteComm to finish transmitting
// S_WAIT_RESP | response timer running; waiting for the response byte
// S_FIN       | every command acked; done pulse
// S_FAIL      | bad response or timeout; buffer flushed
module knight_cmd_sequencer #(
  parameter int          DEPTH    = 16,
  parameter logic [23:0] TMO_CLKS = 24'hFFFFFF,
  parameter logic [7:0]  ACK      = 8'hA5,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [15:0]   wr_cmd,
  input  logic          go,
  input  logic          cmd_snt,
  input  logic          resp_rdy,
  input  logic [7:0]    resp,
  output logic [15:0]   cmd,
  output logic          snd_cmd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] err_idx,
  output logic [AW:0]   count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_SNT,
    S_WAIT_RESP,
    S_FIN,
    S_FAIL
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] n_acked;
  logic [23:0]   tmr;

  logic go_ok, wr_ok, ack_ok, nak, tmo;

  assign go_ok  = (state == S_IDLE) && go && (count != '0);
  assign wr_ok  = (state == S_IDLE) && wr_en && (count != FULL);
  assign ack_ok = (state == S_WAIT_RESP) && resp_rdy && (resp == ACK);
  assign nak    = (state == S_WAIT_RESP) && resp_rdy && (resp != ACK);
  // The timer reaching zero without a response is a timeout; a resp_rdy in
  // the same clock takes priority.
  assign tmo    = (state == S_WAIT_RESP) && !resp_rdy && (tmr == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (go_ok) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_SEND;
      S_SEND:      state_nxt = S_WAIT_SNT;
      S_WAIT_SNT:  if (cmd_snt) state_nxt = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (ack_ok)   state_nxt = (count == ONE) ? S_FIN : S_LOAD;
        else if (nak) state_nxt = S_FAIL;
        else if (tmo) state_nxt = S_FAIL;
      end
      S_FIN:       state_nxt = S_IDLE;
      S_FAIL:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Strobes and busy, decoded from the current state.
  always_comb begin
    snd_cmd = (state == S_SEND);
    done    = (state == S_FIN);
    busy    = (state == S_LOAD) || (state == S_SEND) ||
              (state == S_WAIT_SNT) || (state == S_WAIT_RESP);
  end

  // Command storage; the storage itself needs no reset because the pointers
  // and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_ptr] <= wr_cmd;
  end

  // Pointers, count, presented command, response timer and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cmd      <= '0;
      tmr      <= '0;
      n_acked  <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
      err_idx  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      if (go_ok) begin
        err      <= 1'b0;
        err_code <= 2'b00;
        err_idx  <= '0;
        n_acked  <= '0;
      end
      if (state == S_LOAD) cmd <= mem[rd_ptr];
      // Down-counter loaded so that it hits zero on the TMO_CLKS-th clock
      // after cmd_snt.
      if ((state == S_WAIT_SNT) && cmd_snt)
        tmr <= TMO_CLKS - 24'd1;
      else if ((state == S_WAIT_RESP) && (tmr != '0))
        tmr <= tmr - 24'd1;
      if (ack_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        count   <= count - 1'b1;
        n_acked <= n_acked + 1'b1;
      end
      if (nak || tmo) begin
        err      <= 1'b1;
        err_code <= nak ? 2'b01 : 2'b10;
        err_idx  <= n_acked;
      end
      if (state == S_FAIL) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end
    end
  end

endmodule
